// File: rtl/chip8_pkg.sv
// chip8 display engine shared types: command opcodes, engine states,
// scroll/sprite constants and the per-command row-count helper.
package chip8_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR     = 2'd0,
    OP_DRAW      = 2'd1,
    OP_SCROLL_DN = 2'd2,
    OP_SCROLL_LR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_MERGE  = 3'd3,
    ST_SCROLL = 3'd4,
    ST_DONE   = 3'd5
  } draw_state_e;

  localparam int SCROLL_LR_PX  = 4;
  localparam int SPRITE16_ROWS = 16;

  // Sprite rows a DRAW walks through: N, or 16 for a wide sprite.
  function automatic logic [7:0] draw_rows(
    input logic       wide,
    input logic [3:0] n
  );
    return wide ? 8'(SPRITE16_ROWS) : {4'd0, n};
  endfunction

endpackage

// File: rtl/chip8_draw_engine_row_xor.sv
// chip8 sprite row merge: XORs up to 16 sprite pixels into one row.
// Ports: old_row, bits (MSB = leftmost pixel), x0, wide -> new_row, hit.
module chip8_sprite_row_xor
  import chip8_pkg::*;
#(
  parameter int DISP_W = 64,
  parameter int WRAP   = 0
) (
  input  logic [DISP_W-1:0] old_row,
  input  logic [15:0]       bits,
  input  logic [7:0]        x0,
  input  logic              wide,
  output logic [DISP_W-1:0] new_row,
  output logic              hit
);

  localparam int XW = $clog2(DISP_W);

  logic [DISP_W-1:0] mask;
  logic [8:0]        col;
  logic [XW-1:0]     col_w;

  // Column x maps to bit DISP_W-1-x, which is ~x over XW bits.
  always_comb begin
    mask  = '0;
    col   = '0;
    col_w = '0;
    for (int i = 0; i < 16; i++) begin
      col   = {1'b0, x0} + 9'(i);
      col_w = col[XW-1:0];
      if (bits[15-i] && (wide || i < 8) &&
          (WRAP != 0 || col < 9'(DISP_W)))
        mask[~col_w] = 1'b1;
    end
  end

  assign new_row = old_row ^ mask;
  assign hit     = |(old_row & mask);

endmodule

// File: rtl/chip8_draw_engine.sv
// chip8 multi-cycle display engine: owns the framebuffer and runs
// CLEAR / DRAW / SCROLL_DN / SCROLL_LR commands over valid/ready.
// Ports: instruction_clk, rst (async high); cmd_valid/cmd_ready,
// cmd_op/x/y/n/addr; mem_rd_en/addr/data (1-cycle read latency);
// done, collision; disp_rd_row -> disp_rd_data (MSB = leftmost).
// Macro CHIP8_SPRITE16_EN: DRAW with N = 0 draws a 16x16 sprite.
module chip8_draw_engine
  import chip8_pkg::*;
#(
  parameter int DISP_W = 64,
  parameter int DISP_H = 32,
  parameter int ADDR_W = 12,
  parameter int WRAP   = 0
) (
  input  logic                      instruction_clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [7:0]                cmd_x,
  input  logic [7:0]                cmd_y,
  input  logic [3:0]                cmd_n,
  input  logic [ADDR_W-1:0]         cmd_addr,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [7:0]                mem_rd_data,
  output logic                      done,
  output logic                      collision,
  input  logic [$clog2(DISP_H)-1:0] disp_rd_row,
  output logic [DISP_W-1:0]         disp_rd_data
);

  localparam int YW = $clog2(DISP_H);

`ifdef CHIP8_SPRITE16_EN
  localparam bit SPR16_EN = 1'b1;
`else
  localparam bit SPR16_EN = 1'b0;
`endif

  draw_state_e state_q;
  draw_state_e state_d;

  logic [DISP_W-1:0] fb [DISP_H];
  logic [DISP_W-1:0] scr [DISP_H];

  cmd_op_e           op_q;
  logic [7:0]        x_q;
  logic [7:0]        y_q;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wide_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [7:0]        cnt_q;
  logic              coll_q;

  logic              accept;
  cmd_op_e           op_in;
  logic [ADDR_W-1:0] rd_off;
  logic [7:0]        y_sum;
  logic [YW-1:0]     row_idx;
  logic              row_ok;
  logic              last_row;
  logic [15:0]       spr_bits;
  logic [DISP_W-1:0] merged;
  logic              merge_hit;

  assign op_in     = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign done      = (state_q == ST_DONE);
  assign collision = done && coll_q;

  // Wide sprites read two bytes per row: offset 2k + phase.
  assign rd_off = wide_q ? ADDR_W'({cnt_q, phase_q})
                         : ADDR_W'(cnt_q);

  assign mem_rd_en   = (state_q == ST_FETCH);
  assign mem_rd_addr = mem_rd_en ? addr_q + rd_off : '0;

  // Rows past the bottom are fetched but skipped when clipping.
  assign y_sum    = y_q + cnt_q;
  assign row_idx  = y_sum[YW-1:0];
  assign row_ok   = (WRAP != 0) || (y_sum < 8'(DISP_H));
  assign last_row = (cnt_q + 8'd1) == draw_rows(wide_q, n_q);

  // In MERGE the bus carries this row's (low) byte.
  assign spr_bits = wide_q ? {hi_q, mem_rd_data}
                           : {mem_rd_data, 8'h00};

  chip8_sprite_row_xor #(
    .DISP_W (DISP_W),
    .WRAP   (WRAP)
  ) u_row_xor (
    .old_row (fb[row_idx]),
    .bits    (spr_bits),
    .x0      (x_q),
    .wide    (wide_q),
    .new_row (merged),
    .hit     (merge_hit)
  );

  assign disp_rd_data = fb[disp_rd_row];

  always_comb begin
    for (int r = 0; r < DISP_H; r++) begin
      scr[r] = '0;
      if (op_q == OP_SCROLL_DN) begin
        if (r >= int'(n_q))
          scr[r] = fb[YW'(r - int'(n_q))];
      end else if (n_q[0]) begin
        scr[r] = fb[r] << SCROLL_LR_PX;
      end else begin
        scr[r] = fb[r] >> SCROLL_LR_PX;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (1'b1)
            op_in == OP_CLEAR:
              state_d = ST_CLEAR;
            op_in == OP_DRAW:
              state_d = (cmd_n != 4'd0 || SPR16_EN)
                        ? ST_FETCH : ST_DONE;
            op_in == OP_SCROLL_DN,
            op_in == OP_SCROLL_LR:
              state_d = ST_SCROLL;
          endcase
        end
      end
      ST_CLEAR: begin
        if (cnt_q == 8'(DISP_H - 1))
          state_d = ST_DONE;
      end
      ST_FETCH: begin
        if (!wide_q || phase_q)
          state_d = ST_MERGE;
      end
      ST_MERGE: begin
        state_d = last_row ? ST_DONE : ST_FETCH;
      end
      ST_SCROLL: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge instruction_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge instruction_clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_CLEAR;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      wide_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      for (int r = 0; r < DISP_H; r++)
        fb[r] <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        x_q     <= cmd_x % 8'(DISP_W);
        y_q     <= cmd_y % 8'(DISP_H);
        n_q     <= cmd_n;
        addr_q  <= cmd_addr;
        wide_q  <= SPR16_EN && op_in == OP_DRAW &&
                   cmd_n == 4'd0;
        phase_q <= 1'b0;
        cnt_q   <= '0;
        coll_q  <= 1'b0;
      end
      unique case (state_q)
        ST_CLEAR: begin
          fb[cnt_q[YW-1:0]] <= '0;
          cnt_q <= cnt_q + 8'd1;
        end
        ST_FETCH: begin
          // Second fetch cycle of a wide row sees the high byte.
          if (wide_q && phase_q)
            hi_q <= mem_rd_data;
          phase_q <= wide_q && !phase_q;
        end
        ST_MERGE: begin
          if (row_ok) begin
            fb[row_idx] <= merged;
            coll_q <= coll_q | merge_hit;
          end
          cnt_q <= cnt_q + 8'd1;
        end
        ST_SCROLL: begin
          for (int r = 0; r < DISP_H; r++)
            fb[r] <= scr[r];
        end
        default: ;
      endcase
    end
  end

endmodule
